// File: rtl/regfile_pkg.sv
// Shared widths, architectural register numbers and types for the MIPS register file.
package regfile_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned REG_ZERO = 0;
    localparam int unsigned REG_V0   = 2;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy bits with an incrementally maintained population count.
// Set (new producer) beats clear (writeback); flush beats everything.
module reg_scoreboard #(
    parameter int unsigned ADDR_W = regfile_pkg::ADDR_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      set_en,
    input  logic [ADDR_W-1:0]         set_addr,
    input  logic                      clr_en_0,
    input  logic [ADDR_W-1:0]         clr_addr_0,
    input  logic                      clr_en_1,
    input  logic [ADDR_W-1:0]         clr_addr_1,
    input  logic                      flush,
    output logic [(1 << ADDR_W)-1:0]  busy,
    output logic [ADDR_W:0]           busy_count
);
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [DEPTH-1:0] busy_next;
    logic [CNT_W-1:0] count_next;
    logic             set_hit;
    logic             inc;
    logic             dec_0;
    logic             dec_1;

    // Next busy vector and count; a bit cleared by both ports is only counted once.
    always_comb begin
        busy_next  = busy;
        count_next = busy_count;
        set_hit    = set_en && (set_addr != '0);
        inc        = set_hit && !busy[set_addr];
        dec_0      = clr_en_0 && busy[clr_addr_0] && !(set_hit && (set_addr == clr_addr_0));
        dec_1      = clr_en_1 && busy[clr_addr_1] && !(set_hit && (set_addr == clr_addr_1))
                     && !(clr_en_0 && (clr_addr_0 == clr_addr_1));
        if (clr_en_0) busy_next[clr_addr_0] = 1'b0;
        if (clr_en_1) busy_next[clr_addr_1] = 1'b0;
        if (set_hit)  busy_next[set_addr]   = 1'b1;
        count_next = busy_count + CNT_W'(inc) - CNT_W'(dec_0) - CNT_W'(dec_1);
        if (flush) begin
            busy_next  = '0;
            count_next = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            busy       <= busy_next;
            busy_count <= count_next;
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-read, dual-write register file with optional write-through bypass and
// a busy scoreboard used by decode for RAW hazard detection.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = regfile_pkg::DATA_W,
    parameter int unsigned ADDR_W = regfile_pkg::ADDR_W,
    parameter int unsigned NUM_RD = 2,
    parameter int unsigned BYPASS = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wen_0,
    input  logic [ADDR_W-1:0]         write_addr_0,
    input  logic [DATA_W-1:0]         write_data_0,
    input  logic                      wen_1,
    input  logic [ADDR_W-1:0]         write_addr_1,
    input  logic [DATA_W-1:0]         write_data_1,
    input  logic [NUM_RD-1:0]         read_en,
    input  logic [NUM_RD*ADDR_W-1:0]  read_addr,
    output logic [NUM_RD*DATA_W-1:0]  read_data,
    output logic [NUM_RD-1:0]         read_busy,
    input  logic                      issue_valid,
    input  logic [ADDR_W-1:0]         issue_dest,
    input  logic                      flush,
    output logic                      stall,
    output logic [ADDR_W:0]           busy_count,
    output logic [DATA_W-1:0]         register_v0
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic              fwd_on;
    logic              wr_0;
    logic              wr_1;

    // Forwarding is suppressed during reset so every output reads 0.
    assign fwd_on = (BYPASS != 0) && !reset;
    assign wr_0   = wen_0 && (write_addr_0 != ADDR_W'(REG_ZERO));
    assign wr_1   = wen_1 && (write_addr_1 != ADDR_W'(REG_ZERO));

    // Storage; the load port is written last so it wins an address collision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned a = 0; a < DEPTH; a++) regs[a] <= '0;
        end else begin
            if (wr_0) regs[write_addr_0] <= write_data_0;
            if (wr_1) regs[write_addr_1] <= write_data_1;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic              hit_0;
        logic              hit_1;

        assign addr  = read_addr[i*ADDR_W +: ADDR_W];
        assign hit_0 = fwd_on && wr_0 && (write_addr_0 == addr);
        assign hit_1 = fwd_on && wr_1 && (write_addr_1 == addr);

        assign read_data[i*DATA_W +: DATA_W] =
            (addr == ADDR_W'(REG_ZERO)) ? '0           :
            hit_1                       ? write_data_1 :
            hit_0                       ? write_data_0 :
                                          regs[addr];
        assign read_busy[i] = busy[addr] && !(hit_0 || hit_1);
    end

    assign stall       = |(read_en & read_busy);
    assign register_v0 = regs[ADDR_W'(REG_V0)];

    reg_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .set_en     (issue_valid && !stall),
        .set_addr   (issue_dest),
        .clr_en_0   (wen_0),
        .clr_addr_0 (write_addr_0),
        .clr_en_1   (wen_1),
        .clr_addr_1 (write_addr_1),
        .flush      (flush),
        .busy       (busy),
        .busy_count (busy_count)
    );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard (default parameters, BYPASS=1).
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wen_0 = 1'b0;
    logic [4:0]  write_addr_0 = '0;
    logic [31:0] write_data_0 = '0;
    logic        wen_1 = 1'b0;
    logic [4:0]  write_addr_1 = '0;
    logic [31:0] write_data_1 = '0;
    logic [1:0]  read_en = '0;
    logic [9:0]  read_addr = '0;
    logic [63:0] read_data;
    logic [1:0]  read_busy;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_dest = '0;
    logic        flush = 1'b0;
    logic        stall;
    logic [5:0]  busy_count;
    logic [31:0] register_v0;

    int n_cmp = 0;
    int n_err = 0;

    regfile_scoreboard dut (
        .clk          (clk),
        .reset        (reset),
        .wen_0        (wen_0),
        .write_addr_0 (write_addr_0),
        .write_data_0 (write_data_0),
        .wen_1        (wen_1),
        .write_addr_1 (write_addr_1),
        .write_data_1 (write_data_1),
        .read_en      (read_en),
        .read_addr    (read_addr),
        .read_data    (read_data),
        .read_busy    (read_busy),
        .issue_valid  (issue_valid),
        .issue_dest   (issue_dest),
        .flush        (flush),
        .stall        (stall),
        .busy_count   (busy_count),
        .register_v0  (register_v0)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wen_0 = 1'b0; wen_1 = 1'b0; issue_valid = 1'b0; flush = 1'b0; read_en = '0;
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #2;
        n_cmp++; if (read_data !== 64'h0) begin n_err++; $display("FAIL reset_read_data got %h exp %h", read_data, 64'h0); end
        n_cmp++; if (busy_count !== 6'd0) begin n_err++; $display("FAIL reset_busy_count got %0d exp 0", busy_count); end
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b exp 0", stall); end
        n_cmp++; if (register_v0 !== 32'h0) begin n_err++; $display("FAIL reset_v0 got %h exp 0", register_v0); end
        tick(); tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_write_read();
        wen_0 = 1'b1; write_addr_0 = 5'd5; write_data_0 = 32'hDEAD_BEEF;
        tick();
        idle();
        read_addr = {5'd5, 5'd0};
        #1;
        n_cmp++; if (read_data[63:32] !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL wr_r5_port1 got %h exp deadbeef", read_data[63:32]); end
        n_cmp++; if (register_v0 !== 32'h0) begin n_err++; $display("FAIL wr_v0_zero got %h exp 0", register_v0); end
        wen_0 = 1'b1; write_addr_0 = 5'd2; write_data_0 = 32'h0000_1234;
        #1;
        n_cmp++; if (register_v0 !== 32'h0) begin n_err++; $display("FAIL v0_not_bypassed got %h exp 0", register_v0); end
        tick();
        idle();
        n_cmp++; if (register_v0 !== 32'h0000_1234) begin n_err++; $display("FAIL v0_after_write got %h exp 1234", register_v0); end
    endtask

    task automatic test_dual_write();
        wen_0 = 1'b1; write_addr_0 = 5'd7; write_data_0 = 32'h11;
        wen_1 = 1'b1; write_addr_1 = 5'd7; write_data_1 = 32'h22;
        read_addr = {5'd0, 5'd7};
        #1;
        n_cmp++; if (read_data[31:0] !== 32'h22) begin n_err++; $display("FAIL dual_bypass got %h exp 22", read_data[31:0]); end
        tick();
        idle();
        #1;
        n_cmp++; if (read_data[31:0] !== 32'h22) begin n_err++; $display("FAIL dual_stored got %h exp 22", read_data[31:0]); end
        wen_0 = 1'b1; write_addr_0 = 5'd8; write_data_0 = 32'h33;
        read_addr = {5'd8, 5'd0};
        #1;
        n_cmp++; if (read_data[63:32] !== 32'h33) begin n_err++; $display("FAIL port0_bypass got %h exp 33", read_data[63:32]); end
        tick();
        idle();
    endtask

    task automatic test_busy();
        issue_valid = 1'b1; issue_dest = 5'd9;
        tick();
        idle();
        read_en = 2'b01; read_addr = {5'd0, 5'd9};
        issue_valid = 1'b1; issue_dest = 5'd10;
        #1;
        n_cmp++; if (read_busy[0] !== 1'b1) begin n_err++; $display("FAIL busy_r9 got %b exp 1", read_busy[0]); end
        n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL stall_r9 got %b exp 1", stall); end
        n_cmp++; if (busy_count !== 6'd1) begin n_err++; $display("FAIL count_r9 got %0d exp 1", busy_count); end
        tick();
        issue_valid = 1'b0;
        #1;
        n_cmp++; if (busy_count !== 6'd1) begin n_err++; $display("FAIL stalled_issue_count got %0d exp 1", busy_count); end
        wen_1 = 1'b1; write_addr_1 = 5'd9; write_data_1 = 32'h5;
        #1;
        n_cmp++; if (read_busy[0] !== 1'b0) begin n_err++; $display("FAIL busy_bypass_r9 got %b exp 0", read_busy[0]); end
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL stall_bypass_r9 got %b exp 0", stall); end
        n_cmp++; if (read_data[31:0] !== 32'h5) begin n_err++; $display("FAIL data_bypass_r9 got %h exp 5", read_data[31:0]); end
        tick();
        idle();
        #1;
        n_cmp++; if (busy_count !== 6'd0) begin n_err++; $display("FAIL count_clear_r9 got %0d exp 0", busy_count); end
        n_cmp++; if (read_busy[0] !== 1'b0) begin n_err++; $display("FAIL busy_clear_r9 got %b exp 0", read_busy[0]); end
    endtask

    task automatic test_set_clear();
        issue_valid = 1'b1; issue_dest = 5'd3;
        tick();
        idle();
        wen_0 = 1'b1; write_addr_0 = 5'd3; write_data_0 = 32'hAB;
        issue_valid = 1'b1; issue_dest = 5'd3;
        tick();
        idle();
        read_addr = {5'd0, 5'd3};
        #1;
        n_cmp++; if (read_busy[0] !== 1'b1) begin n_err++; $display("FAIL set_wins_busy got %b exp 1", read_busy[0]); end
        n_cmp++; if (busy_count !== 6'd1) begin n_err++; $display("FAIL set_wins_count got %0d exp 1", busy_count); end
        wen_0 = 1'b1; write_addr_0 = 5'd3; write_data_0 = 32'hCD;
        tick();
        idle();
        n_cmp++; if (busy_count !== 6'd0) begin n_err++; $display("FAIL set_clear_final got %0d exp 0", busy_count); end
    endtask

    task automatic test_flush();
        issue_valid = 1'b1; issue_dest = 5'd11; tick();
        issue_dest = 5'd12; tick();
        issue_dest = 5'd13; tick();
        idle();
        n_cmp++; if (busy_count !== 6'd3) begin n_err++; $display("FAIL pre_flush_count got %0d exp 3", busy_count); end
        flush = 1'b1; issue_valid = 1'b1; issue_dest = 5'd4;
        tick();
        idle();
        read_addr = {5'd11, 5'd4};
        #1;
        n_cmp++; if (busy_count !== 6'd0) begin n_err++; $display("FAIL flush_count got %0d exp 0", busy_count); end
        n_cmp++; if (read_busy !== 2'b00) begin n_err++; $display("FAIL flush_busy got %b exp 00", read_busy); end
        read_addr = {5'd7, 5'd5};
        #1;
        n_cmp++; if (read_data !== {32'h22, 32'hDEAD_BEEF}) begin n_err++; $display("FAIL flush_data got %h exp 00000022deadbeef", read_data); end
    endtask

    task automatic test_zero();
        wen_0 = 1'b1; write_addr_0 = 5'd0; write_data_0 = 32'hFFFF_FFFF;
        issue_valid = 1'b1; issue_dest = 5'd0;
        read_en = 2'b01; read_addr = {5'd0, 5'd0};
        #1;
        n_cmp++; if (read_data[31:0] !== 32'h0) begin n_err++; $display("FAIL r0_bypass got %h exp 0", read_data[31:0]); end
        tick();
        idle();
        read_en = 2'b01;
        #1;
        n_cmp++; if (read_data[31:0] !== 32'h0) begin n_err++; $display("FAIL r0_stored got %h exp 0", read_data[31:0]); end
        n_cmp++; if (read_busy[0] !== 1'b0) begin n_err++; $display("FAIL r0_busy got %b exp 0", read_busy[0]); end
        n_cmp++; if (busy_count !== 6'd0) begin n_err++; $display("FAIL r0_count got %0d exp 0", busy_count); end
        read_en = '0;
    endtask

    task automatic test_reset_midrun();
        issue_valid = 1'b1; issue_dest = 5'd6;
        tick();
        idle();
        read_en = 2'b11; read_addr = {5'd5, 5'd6};
        wen_0 = 1'b1; write_addr_0 = 5'd5; write_data_0 = 32'h7777;
        #1;
        n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL pre_reset_stall got %b exp 1", stall); end
        reset = 1'b1;
        #1;
        n_cmp++; if (read_data !== 64'h0) begin n_err++; $display("FAIL midrun_read_data got %h exp 0", read_data); end
        n_cmp++; if (busy_count !== 6'd0) begin n_err++; $display("FAIL midrun_count got %0d exp 0", busy_count); end
        n_cmp++; if (stall !== 1'b0 || read_busy !== 2'b00) begin n_err++; $display("FAIL midrun_stall got %b/%b exp 0/00", stall, read_busy); end
        n_cmp++; if (register_v0 !== 32'h0) begin n_err++; $display("FAIL midrun_v0 got %h exp 0", register_v0); end
        idle();
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_dual_write();
        test_busy();
        test_set_clear();
        test_flush();
        test_zero();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
